// File: rtl/l2_infer_if.sv
// Bus between the L2 inference core and its environment (event inputs, weights, spike/trainer outputs).
// o_drop_cnt is present only when ODESA_L2_DROPCNT_EN is defined.
interface l2_infer_if #(parameter int p_width = 9);
  logic [2:1]                    i_event;
  logic [4*2*p_width-1:0]        i_weights;
  logic [4*(2*p_width+1)-1:0]    i_thresholds;
  logic [4:1]                    o_l2_spikeout;
  logic [2*p_width-1:0]          o_ts;
  logic [4*(2*p_width+1)-1:0]    o_lv;
  logic                          o_busy;
`ifdef ODESA_L2_DROPCNT_EN
  logic [15:0]                   o_drop_cnt;
  modport master (output i_event, i_weights, i_thresholds,
                  input  o_l2_spikeout, o_ts, o_lv, o_busy, o_drop_cnt);
  modport slave  (input  i_event, i_weights, i_thresholds,
                  output o_l2_spikeout, o_ts, o_lv, o_busy, o_drop_cnt);
`else
  modport master (output i_event, i_weights, i_thresholds,
                  input  o_l2_spikeout, o_ts, o_lv, o_busy);
  modport slave  (input  i_event, i_weights, i_thresholds,
                  output o_l2_spikeout, o_ts, o_lv, o_busy);
`endif
endinterface

// File: rtl/l2_infer.sv
// ODESA layer-2 inference: per-channel decaying time surfaces, 4-neuron MAC, thresholded WTA spike.
// Optional dropped-event counter enabled by ODESA_L2_DROPCNT_EN.

// One channel's time surface: load to all-ones on event, else decay 1 LSB per p_decay_clks.
module l2_surface #(
  parameter int p_width      = 9,
  parameter int p_decay_clks = 4
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_load,
  output logic [p_width-1:0] o_ts
);
  localparam int PW = (p_decay_clks > 1) ? $clog2(p_decay_clks) : 1;

  logic [p_width-1:0] ts_q, ts_d;
  logic [PW-1:0]      presc_q, presc_d;

  always_comb begin
    ts_d    = ts_q;
    presc_d = presc_q;
    if (i_load) begin
      ts_d    = '1;
      presc_d = '0;
    end else if (presc_q == PW'(p_decay_clks-1)) begin
      presc_d = '0;
      if (ts_q != '0) ts_d = ts_q - 1'b1;
    end else begin
      presc_d = presc_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ts_q    <= '0;
      presc_q <= '0;
    end else begin
      ts_q    <= ts_d;
      presc_q <= presc_d;
    end
  end

  assign o_ts = ts_q;
endmodule

module l2_infer #(
  parameter int p_width      = 9,
  parameter int p_decay_clks = 4,
  parameter int p_spike_clks = 3
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  l2_infer_if.slave     bus
);
  localparam int LW = 2*p_width+1;
  localparam int FW = (p_spike_clks > 1) ? $clog2(p_spike_clks) : 1;

  typedef enum logic [2:0] {IDLE, SNAP, MAC1, MAC2, MAC3, MAC4, CMP, FIRE} state_t;

  state_t                        state_q, state_d;
  logic [2:1]                    ev_prev_q, ev;
  logic [2:1][p_width-1:0]       ts;
  logic [2:1][p_width-1:0]       snap_ts_q, snap_ts_d;
  logic [3:0][1:0][p_width-1:0]  w_q, w_d;
  logic [3:0][LW-1:0]            thr_q, thr_d, lv_q, lv_d;
  logic [3:0]                    spike_q, spike_d;
  logic                          busy_q, busy_d;
  logic [FW-1:0]                 fire_q, fire_d;

  assign ev = bus.i_event & ~ev_prev_q;

  for (genvar c = 1; c <= 2; c++) begin : g_surf
    l2_surface #(.p_width(p_width), .p_decay_clks(p_decay_clks)) u_surf (
      .i_clk  (i_clk),
      .i_rst_n(i_rst_n),
      .i_load (ev[c]),
      .o_ts   (ts[c])
    );
  end

  // One shared multiplier pair, steered to the neuron of the current MAC state.
  logic [1:0]           mac_idx;
  logic [2*p_width-1:0] prod1, prod2;
  logic [LW-1:0]        mac_sum;

  always_comb begin
    mac_idx = 2'd0;
    case (state_q)
      MAC2:    mac_idx = 2'd1;
      MAC3:    mac_idx = 2'd2;
      MAC4:    mac_idx = 2'd3;
      default: mac_idx = 2'd0;
    endcase
    prod1   = (2*p_width)'(w_q[mac_idx][0]) * (2*p_width)'(snap_ts_q[1]);
    prod2   = (2*p_width)'(w_q[mac_idx][1]) * (2*p_width)'(snap_ts_q[2]);
    mac_sum = LW'(prod1) + LW'(prod2);
  end

  // Strict '>' keeps the lowest index on ties.
  logic          win_vld;
  logic [1:0]    win_idx;
  logic [LW-1:0] win_lv;

  always_comb begin
    win_vld = 1'b0;
    win_idx = 2'd0;
    win_lv  = '0;
    for (int n = 0; n < 4; n++) begin
      if (lv_q[n] >= thr_q[n] && (!win_vld || lv_q[n] > win_lv)) begin
        win_vld = 1'b1;
        win_idx = 2'(n);
        win_lv  = lv_q[n];
      end
    end
  end

`ifdef ODESA_L2_DROPCNT_EN
  logic [15:0] drop_q, drop_d;
  always_comb begin
    drop_d = drop_q;
    if (state_q != IDLE && ev != '0 && drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
  end
  assign bus.o_drop_cnt = drop_q;
`endif

  // Snapshot is taken on the IDLE->SNAP edge so the surfaces are sampled before this edge's decay.
  always_comb begin
    state_d   = state_q;
    snap_ts_d = snap_ts_q;
    w_d       = w_q;
    thr_d     = thr_q;
    lv_d      = lv_q;
    spike_d   = spike_q;
    busy_d    = busy_q;
    fire_d    = fire_q;
    case (state_q)
      IDLE: if (ev != '0) begin
        state_d = SNAP;
        busy_d  = 1'b1;
        for (int c = 1; c <= 2; c++) snap_ts_d[c] = ev[c] ? '1 : ts[c];
        w_d     = bus.i_weights;
        thr_d   = bus.i_thresholds;
      end
      SNAP: state_d = MAC1;
      MAC1: begin lv_d[0] = mac_sum; state_d = MAC2; end
      MAC2: begin lv_d[1] = mac_sum; state_d = MAC3; end
      MAC3: begin lv_d[2] = mac_sum; state_d = MAC4; end
      MAC4: begin lv_d[3] = mac_sum; state_d = CMP;  end
      CMP: if (win_vld) begin
        spike_d = 4'b0001 << win_idx;
        fire_d  = '0;
        state_d = FIRE;
      end else begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      FIRE: if (fire_q == FW'(p_spike_clks-1)) begin
        spike_d = '0;
        busy_d  = 1'b0;
        state_d = IDLE;
      end else begin
        fire_d  = fire_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= IDLE;
      ev_prev_q <= '0;
      snap_ts_q <= '0;
      w_q       <= '0;
      thr_q     <= '0;
      lv_q      <= '0;
      spike_q   <= '0;
      busy_q    <= 1'b0;
      fire_q    <= '0;
`ifdef ODESA_L2_DROPCNT_EN
      drop_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      ev_prev_q <= bus.i_event;
      snap_ts_q <= snap_ts_d;
      w_q       <= w_d;
      thr_q     <= thr_d;
      lv_q      <= lv_d;
      spike_q   <= spike_d;
      busy_q    <= busy_d;
      fire_q    <= fire_d;
`ifdef ODESA_L2_DROPCNT_EN
      drop_q    <= drop_d;
`endif
    end
  end

  assign bus.o_l2_spikeout = spike_q;
  assign bus.o_ts          = snap_ts_q;
  assign bus.o_lv          = lv_q;
  assign bus.o_busy        = busy_q;
endmodule
